// File: rtl/tcb_pkg.sv
// Shared TCB types and constants used by TCB managers and their response-capture logic.
package tcb_pkg;

    localparam int unsigned TCB_AW      = 32;
    localparam int unsigned TCB_DW      = 32;
    localparam int unsigned TCB_BW      = TCB_DW / 8;
    localparam int unsigned TCB_DLY_MAX = 2;

    typedef struct packed {
        logic              wen;
        logic [TCB_AW-1:0] adr;
        logic [TCB_BW-1:0] ben;
        logic [TCB_DW-1:0] wdt;
    } tcb_cmd_t;

    typedef struct packed {
        logic              wen;
        logic [TCB_DW-1:0] rdt;
        logic              err;
    } tcb_rsp_t;

    function automatic bit is_pow2(input int unsigned n);
        return (n != 0) && ((n & (n - 1)) == 0);
    endfunction

endpackage

// File: rtl/tcb_if.sv
// TCB bus interface; the manager drives clk/rst and the request, the subordinate answers DLY cycles later.
interface tcb_if
    import tcb_pkg::*;
#(
    parameter int unsigned AW  = 32,
    parameter int unsigned DW  = 32,
    parameter int unsigned DLY = 1
)();

    logic            clk;
    logic            rst;
    logic            vld;
    logic            wen;
    logic [AW-1:0]   adr;
    logic [DW/8-1:0] ben;
    logic [DW-1:0]   wdt;
    logic            rdy;
    logic [DW-1:0]   rdt;
    logic            err;

    if (DLY > TCB_DLY_MAX) begin : g_err_dly
        $error("tcb_if: DLY exceeds TCB_DLY_MAX");
    end

    modport man (output clk, rst, vld, wen, adr, ben, wdt, input rdy, rdt, err);
    modport sub (input clk, rst, vld, wen, adr, ben, wdt, output rdy, rdt, err);

endinterface

// File: rtl/tcb_rsp_fifo.sv
// Synchronous response FIFO of tcb_rsp_t; head is presented combinationally, push and pop may coincide.
module tcb_rsp_fifo
    import tcb_pkg::*;
#(
    parameter int unsigned RD = 4
)(
    input  logic     clk,
    input  logic     rst_n,
    input  logic     i_push,
    input  tcb_rsp_t i_data,
    input  logic     i_pop,
    output tcb_rsp_t o_data,
    output logic     o_full,
    output logic     o_empty
);

    localparam int unsigned PW = $clog2(RD);

    if (!is_pow2(RD) || RD < 2) begin : g_err_rd
        $error("tcb_rsp_fifo: RD must be a power of 2 and at least 2");
    end

    tcb_rsp_t      r_mem [RD];
    logic [PW:0]   r_wr_ptr;
    logic [PW:0]   r_rd_ptr;
    logic          w_push;
    logic          w_pop;

    assign o_empty = (r_wr_ptr == r_rd_ptr);
    assign o_full  = (r_wr_ptr[PW] != r_rd_ptr[PW]) && (r_wr_ptr[PW-1:0] == r_rd_ptr[PW-1:0]);

    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign w_push = i_push & (~o_full | i_pop);
    assign w_pop  = i_pop & ~o_empty;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + (PW+1)'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + (PW+1)'(1);
        end
    end

    // NOTE: storage is deliberately not reset; empty/full come from the pointers alone.
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr[PW-1:0]] <= i_data;
    end

    assign o_data = r_mem[r_rd_ptr[PW-1:0]];

endmodule

// File: rtl/tcb_cmd_man.sv
// TCB manager: turns a valid/ready command stream into TCB transfers and returns one in-order response each.
module tcb_cmd_man
    import tcb_pkg::*;
#(
    parameter int unsigned AW  = 32,
    parameter int unsigned DW  = 32,
    parameter int unsigned DLY = 1,
    parameter int unsigned RD  = 4
)(
    input  logic            clk,
    input  logic            rst,
    input  logic            cmd_vld,
    output logic            cmd_rdy,
    input  logic            cmd_wen,
    input  logic [AW-1:0]   cmd_adr,
    input  logic [DW/8-1:0] cmd_ben,
    input  logic [DW-1:0]   cmd_wdt,
    output logic            rsp_vld,
    input  logic            rsp_rdy,
    output logic            rsp_wen,
    output logic [DW-1:0]   rsp_rdt,
    output logic            rsp_err,
    tcb_if.man              bus
);

    localparam int unsigned OW = $clog2(RD + 1);

    if (DLY != bus.DLY) begin : g_err_dly
        $error("tcb_cmd_man: DLY differs from bus.DLY");
    end
    if (DW != bus.DW || DW != TCB_DW) begin : g_err_dw
        $error("tcb_cmd_man: DW differs from bus.DW or the package width");
    end
    if (AW != bus.AW || AW != TCB_AW) begin : g_err_aw
        $error("tcb_cmd_man: AW differs from bus.AW or the package width");
    end
    if (RD < DLY + 1) begin : g_err_rd_dly
        $error("tcb_cmd_man: RD must be at least DLY+1");
    end
    if (!is_pow2(RD)) begin : g_err_rd_pow2
        $error("tcb_cmd_man: RD must be a power of 2");
    end
    if (DLY > TCB_DLY_MAX) begin : g_err_dly_max
        $error("tcb_cmd_man: DLY exceeds TCB_DLY_MAX");
    end

    logic            r_run;
    logic            r_vld;
    tcb_cmd_t        r_req;
    logic [OW-1:0]   r_out;
    logic            w_trn;
    logic            w_credit;
    logic            w_cmd_hs;
    logic            w_pop;

    assign w_trn    = r_vld & bus.rdy;
    // The pending request already owns a FIFO slot, so it counts against the credit.
    assign w_credit = (r_out + OW'(r_vld)) < OW'(RD);
    assign cmd_rdy  = r_run & w_credit & (~r_vld | bus.rdy);
    assign w_cmd_hs = cmd_vld & cmd_rdy;
    assign w_pop    = rsp_vld & rsp_rdy;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_run <= 1'b0;
            r_vld <= 1'b0;
            r_req <= '0;
            r_out <= '0;
        end else begin
            r_run <= 1'b1;
            if (w_cmd_hs) begin
                r_vld <= 1'b1;
                r_req <= '{wen: cmd_wen, adr: cmd_adr, ben: cmd_ben, wdt: cmd_wdt};
            end else if (w_trn) begin
                r_vld <= 1'b0;
            end
            if (w_trn && !w_pop) begin
                r_out <= r_out + OW'(1);
            end else if (!w_trn && w_pop) begin
                r_out <= r_out - OW'(1);
            end
        end
    end

    assign bus.clk = clk;
    assign bus.rst = ~rst;
    assign bus.vld = r_vld;
    assign bus.wen = r_req.wen;
    assign bus.adr = r_req.adr;
    assign bus.ben = r_req.ben;
    assign bus.wdt = r_req.wdt;

    logic w_cap_vld;
    logic w_cap_wen;

    if (DLY == 0) begin : g_dly0
        assign w_cap_vld = w_trn;
        assign w_cap_wen = r_req.wen;
    end else begin : g_dly
        logic [DLY-1:0] r_dl_vld;
        logic [DLY-1:0] r_dl_wen;

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                r_dl_vld <= '0;
                r_dl_wen <= '0;
            end else begin
                r_dl_vld[0] <= w_trn;
                r_dl_wen[0] <= r_req.wen;
                for (int i = 1; i < DLY; i++) begin
                    r_dl_vld[i] <= r_dl_vld[i-1];
                    r_dl_wen[i] <= r_dl_wen[i-1];
                end
            end
        end

        assign w_cap_vld = r_dl_vld[DLY-1];
        assign w_cap_wen = r_dl_wen[DLY-1];
    end

    tcb_rsp_t w_cap;
    tcb_rsp_t w_head;
    logic     w_full;
    logic     w_empty;

    assign w_cap = '{wen: w_cap_wen, rdt: bus.rdt & {DW{~w_cap_wen}}, err: bus.err};

    tcb_rsp_fifo #(.RD(RD)) u_fifo (
        .clk     (clk),
        .rst_n   (rst),
        .i_push  (w_cap_vld),
        .i_data  (w_cap),
        .i_pop   (w_pop),
        .o_data  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    assign rsp_vld = ~w_empty;
    assign rsp_wen = w_head.wen;
    assign rsp_rdt = w_head.rdt;
    assign rsp_err = w_head.err;

    a_no_overflow: assert property (@(posedge clk) disable iff (!rst) (w_cap_vld && w_full) |-> w_pop);

endmodule

// File: tb/tb_tcb_cmd_man.sv
// Bench for tcb_cmd_man: directed scenarios plus random traffic against a command-level reference model.
module tb_tcb_cmd_man;

    localparam int unsigned AW  = 32;
    localparam int unsigned DW  = 32;
    localparam int unsigned DLY = 1;
    localparam int unsigned RD  = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        cmd_vld = 1'b0;
    logic        cmd_rdy;
    logic        cmd_wen = 1'b0;
    logic [31:0] cmd_adr = '0;
    logic [3:0]  cmd_ben = '0;
    logic [31:0] cmd_wdt = '0;
    logic        rsp_vld;
    logic        rsp_rdy = 1'b0;
    logic        rsp_wen;
    logic [31:0] rsp_rdt;
    logic        rsp_err;

    always #5 clk = ~clk;

    tcb_if #(.AW(AW), .DW(DW), .DLY(DLY)) bus ();

    tcb_cmd_man #(.AW(AW), .DW(DW), .DLY(DLY), .RD(RD)) dut (
        .clk     (clk),
        .rst     (rst),
        .cmd_vld (cmd_vld),
        .cmd_rdy (cmd_rdy),
        .cmd_wen (cmd_wen),
        .cmd_adr (cmd_adr),
        .cmd_ben (cmd_ben),
        .cmd_wdt (cmd_wdt),
        .rsp_vld (rsp_vld),
        .rsp_rdy (rsp_rdy),
        .rsp_wen (rsp_wen),
        .rsp_rdt (rsp_rdt),
        .rsp_err (rsp_err),
        .bus     (bus)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Subordinate: 16-word memory, one-cycle read latency, error on err_adr.
    logic [31:0] err_adr = 32'hFFFF_FFFF;
    logic [31:0] smem [16];

    always @(posedge clk) begin
        if (bus.vld && bus.rdy) begin
            if (bus.wen) begin
                if (bus.adr != err_adr)
                    for (int b = 0; b < 4; b++)
                        if (bus.ben[b]) smem[bus.adr[5:2]][8*b +: 8] <= bus.wdt[8*b +: 8];
                bus.rdt <= $urandom();
            end else begin
                bus.rdt <= smem[bus.adr[5:2]];
            end
            bus.err <= (bus.adr == err_adr);
        end
    end

    // Reference model: each accepted command yields its response immediately, in order.
    logic [31:0] mmem [16];
    logic [33:0] exp_q [$];

    task automatic model_cmd(input logic wen, input logic [31:0] adr, input logic [3:0] ben, input logic [31:0] wdt);
        logic err;
        int   idx;
        err = (adr == err_adr);
        idx = int'(adr[5:2]);
        if (wen) begin
            if (!err)
                for (int b = 0; b < 4; b++)
                    if (ben[b]) mmem[idx][8*b +: 8] = wdt[8*b +: 8];
            exp_q.push_back({1'b1, 32'h0, err});
        end else begin
            exp_q.push_back({1'b0, mmem[idx], err});
        end
    endtask

    task automatic issue(input logic wen, input logic [31:0] adr, input logic [3:0] ben, input logic [31:0] wdt);
        int t;
        cmd_vld = 1'b1;
        cmd_wen = wen;
        cmd_adr = adr;
        cmd_ben = ben;
        cmd_wdt = wdt;
        t = 0;
        @(negedge clk);
        while (!cmd_rdy && t < 400) begin
            @(negedge clk);
            t++;
        end
        check("cmd_accept", 64'(cmd_rdy), 64'd1);
        if (cmd_rdy) model_cmd(wen, adr, ben, wdt);
        @(posedge clk);
        #1;
        cmd_vld = 1'b0;
    endtask

    int cyc = 0;
    int n_trn = 0;
    int n_rsp = 0;
    int n_err_rsp = 0;
    int trn_cyc [$];

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (bus.vld && bus.rdy) begin
            n_trn++;
            trn_cyc.push_back(cyc);
        end
        if (rst && rsp_vld && rsp_rdy) begin
            n_rsp++;
            if (rsp_err) n_err_rsp++;
            if (exp_q.size() == 0) begin
                check("rsp_expected", 64'(exp_q.size()), 64'd1);
            end else begin
                logic [33:0] e;
                e = exp_q.pop_front();
                check("rsp_wen", 64'(rsp_wen), 64'(e[33]));
                check("rsp_rdt", 64'(rsp_rdt), 64'(e[32:1]));
                check("rsp_err", 64'(rsp_err), 64'(e[0]));
            end
        end
    end

    bit rand_rdy = 1'b0;
    bit rand_rsp = 1'b0;

    always @(posedge clk) begin
        #1;
        if (rand_rdy) bus.rdy = ($urandom_range(0, 9) < 7);
        if (rand_rsp) rsp_rdy = ($urandom_range(0, 9) < 6);
    end

    task automatic drain(input string tag);
        for (int t = 0; t < 600 && exp_q.size() != 0; t++) @(posedge clk);
        #1;
        check(tag, 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1);
    end

    bit done3 = 1'b0;

    initial begin
        int base_trn;
        int base_rsp;
        int base_err;
        bus.rdy = 1'b1;
        bus.rdt = '0;
        bus.err = 1'b0;
        for (int i = 0; i < 16; i++) begin
            smem[i] = $urandom();
            mmem[i] = smem[i];
        end

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_cmd_rdy", 64'(cmd_rdy), 64'd0);
        check("rst_rsp_vld", 64'(rsp_vld), 64'd0);
        check("rst_bus_vld", 64'(bus.vld), 64'd0);
        check("rst_bus_adr", 64'(bus.adr), 64'd0);
        check("rst_bus_wdt", 64'(bus.wdt), 64'd0);
        check("rst_bus_wen_ben", 64'({bus.wen, bus.ben}), 64'd0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("cmd_rdy_after_rst", 64'(cmd_rdy), 64'd1);
        rsp_rdy = 1'b1;

        // Single read with known data
        smem[2] = 32'hCAFE_0001;
        mmem[2] = 32'hCAFE_0001;
        issue(1'b0, 32'h8, 4'hF, 32'h0);
        check("t1_bus_vld", 64'(bus.vld), 64'd1);
        check("t1_bus_adr", 64'(bus.adr), 64'h8);
        @(posedge clk);
        #1;
        check("t1_rsp_vld_early", 64'(rsp_vld), 64'd0);
        @(posedge clk);
        #1;
        check("t1_rsp_vld", 64'(rsp_vld), 64'd1);
        check("t1_rsp_rdt", 64'(rsp_rdt), 64'hCAFE_0001);
        check("t1_rsp_wen_err", 64'({rsp_wen, rsp_err}), 64'd0);
        drain("t1_drain");

        // Eight back-to-back writes
        base_trn = n_trn;
        for (int i = 0; i < 8; i++) issue(1'b1, 32'(4 * i), 4'hF, $urandom());
        drain("t2_drain");
        check("t2_trn_count", 64'(n_trn - base_trn), 64'd8);
        check("t2_no_gaps", 64'(trn_cyc[base_trn + 7] - trn_cyc[base_trn]), 64'd7);

        // Response back-pressure bounds outstanding transfers to RD
        @(posedge clk);
        #1;
        rsp_rdy = 1'b0;
        base_trn = n_trn;
        base_rsp = n_rsp;
        fork
            begin
                for (int k = 0; k < 10; k++) issue(1'b0, 32'(4 * k), 4'hF, 32'h0);
                done3 = 1'b1;
            end
        join_none
        repeat (20) @(posedge clk);
        #1;
        check("t3_trn_bounded", 64'(n_trn - base_trn), 64'(RD));
        check("t3_cmd_rdy_low", 64'(cmd_rdy), 64'd0);
        rsp_rdy = 1'b1;
        for (int t = 0; t < 400 && !(done3 && exp_q.size() == 0); t++) @(posedge clk);
        #1;
        check("t3_all_rsp", 64'(n_rsp - base_rsp), 64'd10);
        check("t3_all_trn", 64'(n_trn - base_trn), 64'd10);

        // Subordinate stall keeps the request stable
        bus.rdy = 1'b0;
        base_rsp = n_rsp;
        issue(1'b1, 32'h4, 4'b0101, 32'h1234_5678);
        for (int s = 0; s < 5; s++) begin
            @(negedge clk);
            check("t4_vld_stable", 64'(bus.vld), 64'd1);
            check("t4_adr_stable", 64'(bus.adr), 64'h4);
            check("t4_wdt_stable", 64'(bus.wdt), 64'h1234_5678);
            check("t4_wen_ben_stable", 64'({bus.wen, bus.ben}), 64'h15);
            check("t4_cmd_rdy_low", 64'(cmd_rdy), 64'd0);
        end
        @(posedge clk);
        #1;
        bus.rdy = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        check("t4_one_rsp", 64'(n_rsp - base_rsp), 64'd1);
        check("t4_bus_idle", 64'(bus.vld), 64'd0);

        // Bus error only on the faulting read
        err_adr = 32'hC;
        base_err = n_err_rsp;
        base_rsp = n_rsp;
        issue(1'b0, 32'h8, 4'hF, 32'h0);
        issue(1'b0, 32'hC, 4'hF, 32'h0);
        issue(1'b0, 32'h10, 4'hF, 32'h0);
        drain("t5_drain");
        check("t5_err_count", 64'(n_err_rsp - base_err), 64'd1);
        check("t5_rsp_count", 64'(n_rsp - base_rsp), 64'd3);
        err_adr = 32'hFFFF_FFFF;

        // Reset with transfers in flight and a response queued
        rsp_rdy = 1'b0;
        issue(1'b0, 32'h0, 4'hF, 32'h0);
        issue(1'b0, 32'h4, 4'hF, 32'h0);
        issue(1'b0, 32'h8, 4'hF, 32'h0);
        check("t6_rsp_queued", 64'(rsp_vld), 64'd1);
        rst = 1'b0;
        exp_q.delete();
        #1;
        check("t6_rst_rsp_vld", 64'(rsp_vld), 64'd0);
        check("t6_rst_bus_vld", 64'(bus.vld), 64'd0);
        check("t6_rst_cmd_rdy", 64'(cmd_rdy), 64'd0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rsp_rdy = 1'b1;
        base_rsp = n_rsp;
        issue(1'b0, 32'h14, 4'hF, 32'h0);
        repeat (10) @(posedge clk);
        #1;
        check("t6_only_new_rsp", 64'(n_rsp - base_rsp), 64'd1);
        check("t6_queue_empty", 64'(exp_q.size()), 64'd0);

        // Random traffic with random back-pressure on both sides
        err_adr = 32'hC;
        rand_rdy = 1'b1;
        rand_rsp = 1'b1;
        for (int n = 0; n < 150; n++)
            issue(1'($urandom_range(0, 1)), {26'd0, 4'($urandom_range(0, 15)), 2'b00},
                  4'($urandom()), $urandom());
        rand_rdy = 1'b0;
        rand_rsp = 1'b0;
        @(posedge clk);
        #1;
        bus.rdy = 1'b1;
        rsp_rdy = 1'b1;
        drain("rand_drain");
        check("rand_idle", 64'({bus.vld, rsp_vld}), 64'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/tcb_cmd_man.md
Name: tcb_cmd_man

Overview:
TCB manager that turns a valid/ready command stream into TCB bus transfers. It returns one response per transfer (read data or write acknowledge, plus error flag) on a valid/ready response stream. It is the initiator counterpart to TCB subordinate peripherals such as the GPIO controller. Typical users are test sequencers, UART/JTAG debug bridges and boot loaders driving the peripheral bus.

Parameters:
AW, 32, address width; must equal bus.AW
DW, 32, data width; must equal bus.DW
DLY, 1, bus read latency in cycles; must equal bus.DLY; legal values 0..2
RD, 4, response FIFO depth (power of 2, RD >= DLY+1); bounds outstanding transfers

Ports:
clk  input  1  clock; also sources bus.clk
rst  input  1  reset, asynchronous, active-low; bus.rst is driven from it (inverted, since bus.rst is active-high)
cmd_vld  input  1  command valid
cmd_rdy  output  1  command ready
cmd_wen  input  1  1=write, 0=read
cmd_adr  input  AW  byte address
cmd_ben  input  DW/8  byte enables
cmd_wdt  input  DW  write data
rsp_vld  output  1  response valid
rsp_rdy  input  1  response ready
rsp_wen  output  1  echo of the command type
rsp_rdt  output  DW  read data; '0 for writes
rsp_err  output  1  bus error
bus  tcb_if.man  -  TCB manager port; uses vld, wen, adr, ben, wdt, rdy, rdt, err

Behaviour:
- Reset (rst=0, async), all of the following hold:
  - bus.vld=0, cmd_rdy=0, rsp_vld=0.
  - Request register cleared; FIFO pointers and outstanding counter = 0.
  - bus.wen/adr/ben/wdt = '0.
  - After release, cmd_rdy=1 from the first clk edge.
- Request stage: single register (req_*).
  - A command handshake (cmd_vld & cmd_rdy) loads req_* on the next edge and sets bus.vld=1.
  - bus.vld and all request fields stay stable until bus.trn (bus.vld & bus.rdy).
  - cmd_rdy = credit & (~bus.vld | bus.rdy), giving back-to-back issue of 1 transfer/cycle.
- Credit:
  - Outstanding counter `out` = transfers issued but not yet written to the FIFO, plus FIFO occupancy. Width clog2(RD+1).
  - credit = (out + bus.vld) < RD.
  - +1 on a bus.trn, -1 on a response pop, both in the same cycle allowed (net 0).
  - The FIFO can never overflow; a response is never dropped.
- Response capture:
  - A delay line of depth DLY carries {valid, wen} for each bus.trn.
  - At t_trn+DLY, bus.rdt and bus.err are sampled into the FIFO. rdt is forced to '0 when wen=1.
  - For DLY=0, capture happens in the trn cycle.
- Response FIFO: RD entries of {wen, rdt, err}.
  - rsp_* is driven from the head; rsp_vld = ~empty.
  - Pop on rsp_vld & rsp_rdy. Push and pop in the same cycle are legal.
  - When full, push and pop in the same cycle are guaranteed only with a pop; credit prevents a push otherwise.
  - Pointers wrap modulo RD, with an extra MSB for the full/empty distinction.
- Ordering: responses are strictly in command order. Latency from command handshake to rsp_vld is 1+DLY+1 cycles minimum (request reg, bus latency, FIFO write).
- bus.rdy low stalls the request register. Commands are not accepted beyond the register while it is stalled.
- Reset mid-operation: in-flight transfers and queued responses are discarded. No response is emitted for them.
- Elaboration checks via $error: DLY!=bus.DLY, DW!=bus.DW, RD<DLY+1, RD not a power of 2.

Decomposition:
- Shared package tcb_pkg holds the following; the response-capture code uses them:
  - typedefs tcb_cmd_t {wen, adr, ben, wdt} and tcb_rsp_t {wen, rdt, err}, parameterised by widths via localparams.
  - constant TCB_DLY_MAX=2.
- One sub-module, tcb_rsp_fifo: synchronous FIFO of tcb_rsp_t with RD entries, push/pop, full/empty. It is reusable by other managers.

Test Plan:
- Single read, DLY=1, subordinate with rdy=1 returns rdt=32'hCAFE_0001 for adr=32'h8 -> bus.vld one cycle after cmd handshake; rsp_vld 3 cycles after handshake with rsp_rdt=32'hCAFE_0001, rsp_err=0, rsp_wen=0.
- 8 back-to-back writes (adr 0,4,...,28), rsp_rdy=1, rdy=1 -> 8 consecutive bus transfers with no gaps; 8 responses in order, rdt='0, err=0.
- rsp_rdy=0 with 10 read commands, RD=4 -> exactly 4 bus transfers, then cmd_rdy=0. Raising rsp_rdy drains the responses in order and resumes issue; all 10 complete.
- Subordinate holds rdy=0 for 5 cycles on a write to adr=32'h4 -> bus.adr, wdt, ben and wen stay stable throughout; cmd_rdy=0 while stalled; exactly one response.
- Subordinate asserts err=1 on the read to adr=32'hC -> only that response has rsp_err=1; neighbouring responses have err=0.
- rst pulled low with 2 transfers outstanding and 1 response queued -> rsp_vld=0 and bus.vld=0 immediately. After release, a new read returns only its own response.
